acc_mem_arbiter: RTL and testbench

Shares the single-port synchronous accumulator-machine memory (16-bit data, 10-bit word address, one-cycle read latency) between the multicycle control/datapath (CPU port) and the IO/DMA requester (IO port). Issues at most one access per cycle, routes read returns back to the issuing port, and bounds IO wait time with a starvation counter. It sits between the control unit's MemAddr/MemData/MemWrite path and the `memory` instance.

---
 rtl/acc_pkg.sv | 18 +
 rtl/arb_starve_ctr.sv | 30 +++
 rtl/acc_mem_arbiter.sv | 104 ++++++++++
 tb/tb_acc_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and defaults for the accumulator-machine memory arbiter.
package acc_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned ADDR_WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_IO   = 2'd2
    } owner_e;

    // Bits needed to count 0..limit inclusive.
    function automatic int unsigned ctr_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles an IO request has waited without a grant.
module arb_starve_ctr
    import acc_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic CLK,
    input  logic Reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam int unsigned CW = ctr_width(LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CW'(LIMIT))) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_at_limit = (r_cnt == CW'(LIMIT));

endmodule

// File: rtl/acc_mem_arbiter.sv
// Single-port memory arbiter between the CPU datapath and the IO/DMA requester,
// with same-cycle grant, read-return routing and bounded IO starvation.
module acc_mem_arbiter
    import acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  io_req,
    input  logic                  io_we,
    input  logic [ADDR_WIDTH-1:0] io_addr,
    input  logic [DATA_WIDTH-1:0] io_wdata,
    output logic                  io_gnt,
    output logic                  io_rvalid,
    output logic [DATA_WIDTH-1:0] io_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    logic                  w_cpu_win;
    logic                  w_io_win;
    logic                  w_at_limit;
    owner_e                w_owner_nxt;
    owner_e                r_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;

    arb_starve_ctr #(
        .LIMIT      (STARVE_LIMIT)
    ) u_starve (
        .CLK        (CLK),
        .Reset      (Reset),
        .i_inc      (io_req & ~w_io_win),
        .i_clr      (~io_req | w_io_win),
        .o_at_limit (w_at_limit)
    );

    // Winner select; no grants while reset is held.
    always_comb begin
        w_cpu_win = 1'b0;
        w_io_win  = 1'b0;
        if (Reset) begin
            if (cpu_req && !(io_req && w_at_limit)) begin
                w_cpu_win = 1'b1;
            end else if (io_req) begin
                w_io_win = 1'b1;
            end
        end
    end

    assign cpu_gnt = w_cpu_win;
    assign io_gnt  = w_io_win;

    // Memory port mux; idle cycles replay the last issued address/data.
    always_comb begin
        mem_addr    = r_addr;
        mem_data    = r_data;
        mem_we      = 1'b0;
        w_owner_nxt = OWN_NONE;
        if (w_cpu_win) begin
            mem_addr    = cpu_addr;
            mem_data    = cpu_wdata;
            mem_we      = cpu_we;
            w_owner_nxt = cpu_we ? OWN_NONE : OWN_CPU;
        end else if (w_io_win) begin
            mem_addr    = io_addr;
            mem_data    = io_wdata;
            mem_we      = io_we;
            w_owner_nxt = io_we ? OWN_NONE : OWN_IO;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_owner <= OWN_NONE;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_owner <= w_owner_nxt;
            if (w_cpu_win || w_io_win) begin
                r_addr <= mem_addr;
                r_data <= mem_data;
            end
        end
    end

    assign cpu_rvalid = (r_owner == OWN_CPU);
    assign io_rvalid  = (r_owner == OWN_IO);
    assign cpu_rdata  = mem_q;
    assign io_rdata   = mem_q;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Self-checking bench for acc_mem_arbiter: directed vector table, reset/idle
// sequences and randomized traffic against a transaction-level reference model.
module tb_acc_mem_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;
    localparam int SL = 4;

    logic          CLK = 1'b0;
    logic          Reset = 1'b0;
    logic          cpu_req, cpu_we, io_req, io_we;
    logic [AW-1:0] cpu_addr, io_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, io_wdata, mem_data, mem_q;
    logic          cpu_gnt, cpu_rvalid, io_gnt, io_rvalid, mem_we;
    logic [DW-1:0] cpu_rdata, io_rdata;

    int total = 0;
    int bad = 0;

    acc_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] init_val(input int i);
        return 16'hA500 ^ DW'(i);
    endfunction

    // The memory the arbiter drives: synchronous, one-cycle read latency.
    logic [DW-1:0] mem [1024];
    initial for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    always @(posedge CLK) begin
        if (mem_we) mem[mem_addr] <= mem_data;
        mem_q <= mem[mem_addr];
    end

    // Reference model: how long IO has waited, which read is in flight, memory image.
    int            m_wait;
    int            m_pend;      // 0 none, 1 cpu, 2 io
    logic [DW-1:0] m_pdata;
    logic [AW-1:0] m_last_addr;
    logic [DW-1:0] m_last_data;
    logic [DW-1:0] ref_mem [1024];
    logic          e_cgnt, e_ignt, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    typedef struct {
        logic cr; logic cw; logic [AW-1:0] ca; logic [DW-1:0] cd;
        logic ir; logic iw; logic [AW-1:0] ia; logic [DW-1:0] id;
        logic cg; logic ig; logic we; logic [AW-1:0] addr;
        logic crv; logic irv; logic [DW-1:0] rd;
    } vec_t;
    vec_t vt [13];

    function automatic vec_t mk(input logic cr, input logic cw, input logic [AW-1:0] ca,
                                input logic [DW-1:0] cd, input logic ir, input logic iw,
                                input logic [AW-1:0] ia, input logic [DW-1:0] id,
                                input logic cg, input logic ig, input logic we,
                                input logic [AW-1:0] addr, input logic crv, input logic irv,
                                input logic [DW-1:0] rd);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.ir = ir; v.iw = iw; v.ia = ia; v.id = id;
        v.cg = cg; v.ig = ig; v.we = we; v.addr = addr; v.crv = crv; v.irv = irv; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic cr, input logic cw, input logic [AW-1:0] ca,
                          input logic [DW-1:0] cd, input logic ir, input logic iw,
                          input logic [AW-1:0] ia, input logic [DW-1:0] id);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        io_req = ir; io_we = iw; io_addr = ia; io_wdata = id;
    endtask

    task automatic model_reset();
        m_wait = 0; m_pend = 0; m_pdata = '0; m_last_addr = '0; m_last_data = '0;
    endtask

    // IO wins only when the CPU is absent or IO has already lost SL cycles in a row.
    task automatic model_eval();
        e_cgnt = cpu_req && !(io_req && (m_wait >= SL));
        e_ignt = io_req && !e_cgnt;
        e_we   = e_cgnt ? cpu_we : (e_ignt ? io_we : 1'b0);
        e_addr = e_cgnt ? cpu_addr : (e_ignt ? io_addr : m_last_addr);
        e_data = e_cgnt ? cpu_wdata : (e_ignt ? io_wdata : m_last_data);
    endtask

    task automatic model_commit();
        m_pend = 0;
        if (e_cgnt || e_ignt) begin
            m_last_addr = e_addr;
            m_last_data = e_data;
            if (e_we) ref_mem[e_addr] = e_data;
            else begin
                m_pend  = e_cgnt ? 1 : 2;
                m_pdata = ref_mem[e_addr];
            end
        end
        m_wait = (io_req && !e_ignt) ? m_wait + 1 : 0;
    endtask

    task automatic check_model();
        chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cgnt));
        chk("io_gnt", 32'(io_gnt), 32'(e_ignt));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_data", 32'(mem_data), 32'(e_data));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_pend == 1));
        chk("io_rvalid", 32'(io_rvalid), 32'(m_pend == 2));
        if (m_pend == 1) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_pdata));
        if (m_pend == 2) chk("io_rdata", 32'(io_rdata), 32'(m_pdata));
    endtask

    // One bus cycle: inputs already applied, check before the edge, then advance.
    task automatic cycle_model();
        model_eval();
        @(negedge CLK);
        check_model();
        model_commit();
        @(posedge CLK);
        #1;
    endtask

    logic          c_act, c_we, i_act, i_we;
    logic [AW-1:0] c_addr, i_addr;
    logic [DW-1:0] c_data, i_data;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        model_reset();
        set_in(1'b1, 1'b1, 10'h3FF, 16'hFFFF, 1'b1, 1'b1, 10'h3FF, 16'hFFFF);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst.cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst.io_gnt", 32'(io_gnt), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst.mem_data", 32'(mem_data), 32'd0);
        chk("rst.rvalid", 32'({cpu_rvalid, io_rvalid}), 32'd0);
        set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        Reset = 1'b1;
        @(posedge CLK);
        #1;

        // Directed table: CPU write/read, IO back-to-back reads, contention with starvation.
        vt[0]  = mk(1'b1, 1'b1, 10'h005, 16'h1234, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b0, 1'b1, 10'h005, 1'b0, 1'b0, 16'h0000);
        vt[1]  = mk(1'b1, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 10'h005, 1'b0, 1'b0, 16'h0000);
        vt[2]  = mk(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 10'h005, 1'b1, 1'b0, 16'h1234);
        vt[3]  = mk(1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 16'h0000);
        vt[4]  = mk(1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b0, 10'h001, 16'h0000, 1'b0, 1'b1, 1'b0, 10'h001, 1'b0, 1'b1, 16'hA500);
        vt[5]  = mk(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 10'h001, 1'b0, 1'b1, 16'hA501);
        vt[6]  = mk(1'b1, 1'b0, 10'h005, 16'h0000, 1'b1, 1'b1, 10'h010, 16'h00AB, 1'b1, 1'b0, 1'b0, 10'h005, 1'b0, 1'b0, 16'h0000);
        for (int k = 7; k <= 9; k++)
            vt[k] = mk(1'b1, 1'b0, 10'h005, 16'h0000, 1'b1, 1'b1, 10'h010, 16'h00AB, 1'b1, 1'b0, 1'b0, 10'h005, 1'b1, 1'b0, 16'h1234);
        vt[10] = mk(1'b1, 1'b0, 10'h010, 16'h0000, 1'b1, 1'b1, 10'h010, 16'h00AB, 1'b0, 1'b1, 1'b1, 10'h010, 1'b1, 1'b0, 16'h1234);
        vt[11] = mk(1'b1, 1'b0, 10'h010, 16'h0000, 1'b1, 1'b1, 10'h010, 16'h00AB, 1'b1, 1'b0, 1'b0, 10'h010, 1'b0, 1'b0, 16'h0000);
        vt[12] = mk(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 10'h010, 1'b1, 1'b0, 16'h00AB);
        for (int k = 0; k < 13; k++) begin
            set_in(vt[k].cr, vt[k].cw, vt[k].ca, vt[k].cd, vt[k].ir, vt[k].iw, vt[k].ia, vt[k].id);
            model_eval();
            @(negedge CLK);
            chk($sformatf("vec%0d.cpu_gnt", k), 32'(cpu_gnt), 32'(vt[k].cg));
            chk($sformatf("vec%0d.io_gnt", k), 32'(io_gnt), 32'(vt[k].ig));
            chk($sformatf("vec%0d.mem_we", k), 32'(mem_we), 32'(vt[k].we));
            chk($sformatf("vec%0d.mem_addr", k), 32'(mem_addr), 32'(vt[k].addr));
            chk($sformatf("vec%0d.cpu_rvalid", k), 32'(cpu_rvalid), 32'(vt[k].crv));
            chk($sformatf("vec%0d.io_rvalid", k), 32'(io_rvalid), 32'(vt[k].irv));
            if (vt[k].crv) chk($sformatf("vec%0d.cpu_rdata", k), 32'(cpu_rdata), 32'(vt[k].rd));
            if (vt[k].irv) chk($sformatf("vec%0d.io_rdata", k), 32'(io_rdata), 32'(vt[k].rd));
            model_commit();
            @(posedge CLK);
            #1;
        end

        // Reset lands in the cycle after a CPU read grant: the read must be dropped.
        set_in(1'b1, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b0, '0, '0);
        cycle_model();
        Reset = 1'b0;
        model_reset();
        @(negedge CLK);
        chk("midrd.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("midrd.cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("midrd.mem_we", 32'(mem_we), 32'd0);
        chk("midrd.mem_addr", 32'(mem_addr), 32'd0);
        chk("midrd.mem_data", 32'(mem_data), 32'd0);
        set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        cycle_model();
        set_in(1'b1, 1'b1, 10'h020, 16'h003C, 1'b0, 1'b0, '0, '0);
        cycle_model();
        set_in(1'b1, 1'b0, 10'h020, 16'h0000, 1'b0, 1'b0, '0, '0);
        cycle_model();

        // Idle: nothing issued, address held, no read returns after the first.
        set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        repeat (10) cycle_model();

        // Randomized traffic; each requester holds its request until granted.
        c_act = 1'b0; i_act = 1'b0;
        c_we = 1'b0; i_we = 1'b0; c_addr = '0; i_addr = '0; c_data = '0; i_data = '0;
        for (int n = 0; n < 400; n++) begin
            if (!c_act && ($urandom_range(0, 3) != 0)) begin
                c_act = 1'b1; c_we = 1'($urandom); c_addr = AW'($urandom_range(0, 15)); c_data = DW'($urandom);
            end
            if (!i_act && ($urandom_range(0, 2) != 0)) begin
                i_act = 1'b1; i_we = 1'($urandom); i_addr = AW'($urandom_range(0, 15)); i_data = DW'($urandom);
            end
            set_in(c_act, c_we, c_addr, c_data, i_act, i_we, i_addr, i_data);
            cycle_model();
            if (e_cgnt) c_act = 1'b0;
            if (e_ignt) i_act = 1'b0;
        end
        set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        repeat (2) cycle_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
